// File: rtl/instruction_fetch_stage.sv
`default_nettype none
// ============================================================================
// Module   : instruction_fetch_stage
// Purpose  : MIPS fetch stage. Owns the PC and the IF/ID register, and handles
//            stall and redirect requests. Optional macro: FETCH_MISALIGN_TRAP_EN.
// Revision : 1.0 - initial release
// ============================================================================
module instruction_fetch_stage #(
   parameter int                    DATA_WIDTH = 32,
   parameter logic [DATA_WIDTH-1:0] RESET_PC   = 32'h0000_0000,
   parameter logic [DATA_WIDTH-1:0] NOP_WORD   = 32'h0000_0000
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  Stall,
   input  logic                  Redirect,
   input  logic [DATA_WIDTH-1:0] RedirectTarget,
   input  logic [DATA_WIDTH-1:0] Instruction,
   output logic [DATA_WIDTH-1:0] PCAddress,
   output logic [DATA_WIDTH-1:0] IFID_Instruction,
   output logic [DATA_WIDTH-1:0] IFID_PCPlus4,
   output logic                  IFID_Valid,
   output logic [31:0]           FetchCount,
   output logic                  MisalignedFetch
);

   localparam logic [DATA_WIDTH-1:0] c_align_mask = {{(DATA_WIDTH-2){1'b1}}, 2'b00};

   logic [DATA_WIDTH-1:0] r_pc;
   logic [DATA_WIDTH-1:0] r_ifid_instr;
   logic [DATA_WIDTH-1:0] r_ifid_pc4;
   logic                  r_ifid_valid;
   logic [31:0]           r_fetch_count;

   logic [DATA_WIDTH-1:0] w_pc_plus4;
   logic [DATA_WIDTH-1:0] w_target_aligned;

   assign w_pc_plus4       = r_pc + DATA_WIDTH'(4);
   assign w_target_aligned = RedirectTarget & c_align_mask;

   // Priority: reset, then redirect (flush), then stall (hold), then fetch.
   always_ff @(posedge clk) begin
      if (!reset) begin
         r_pc          <= RESET_PC;
         r_ifid_instr  <= NOP_WORD;
         r_ifid_pc4    <= '0;
         r_ifid_valid  <= 1'b0;
         r_fetch_count <= '0;
      end else if (Redirect) begin
         r_pc          <= w_target_aligned;
         r_ifid_instr  <= NOP_WORD;
         r_ifid_pc4    <= '0;
         r_ifid_valid  <= 1'b0;
      end else if (!Stall) begin
         r_pc          <= w_pc_plus4;
         r_ifid_instr  <= Instruction;
         r_ifid_pc4    <= w_pc_plus4;
         r_ifid_valid  <= 1'b1;
         r_fetch_count <= r_fetch_count + 32'd1;
      end
   end

`ifdef FETCH_MISALIGN_TRAP_EN
   logic r_misaligned;

   always_ff @(posedge clk) begin
      if (!reset) begin
         r_misaligned <= 1'b0;
      end else if (Redirect && (RedirectTarget[1:0] != 2'b00)) begin
         r_misaligned <= 1'b1;
      end
   end

   assign MisalignedFetch = r_misaligned;
`else
   assign MisalignedFetch = 1'b0;
`endif

   assign PCAddress        = r_pc;
   assign IFID_Instruction = r_ifid_instr;
   assign IFID_PCPlus4     = r_ifid_pc4;
   assign IFID_Valid       = r_ifid_valid;
   assign FetchCount       = r_fetch_count;

endmodule
`default_nettype wire

// File: doc/instruction_fetch_stage.md
Name: instruction_fetch_stage

Overview:
- Front end of the pipelined MIPS core: owns the program counter, drives the word address into the combinational program memory, and latches the returned instruction into the IF/ID pipeline register.
- Handles stall (hold) and redirect (branch/jump target load with IF/ID flush) requests coming from later stages.
- Also keeps a fetched-instruction counter for debug and CPI measurement.

Parameters:
- DATA_WIDTH, 32, width of PC, addresses and instructions.
- RESET_PC, 32'h0000_0000, PC value loaded on reset; must be word aligned.
- NOP_WORD, 32'h0000_0000, instruction value inserted into IF/ID on reset or flush (sll $0,$0,0).

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-low reset.
- Stall  input  1  hold PC and IF/ID contents (load-use hazard from ID).
- Redirect  input  1  taken branch/jump; load RedirectTarget and flush IF/ID.
- RedirectTarget  input  DATA_WIDTH  next PC when Redirect=1.
- Instruction  input  DATA_WIDTH  word returned by program memory for PCAddress (same-cycle, combinational).
- PCAddress  output  DATA_WIDTH  current PC, driven to program memory Address.
- IFID_Instruction  output  DATA_WIDTH  latched instruction for decode.
- IFID_PCPlus4  output  DATA_WIDTH  latched PC+4 of that instruction.
- IFID_Valid  output  1  1 = IF/ID holds a real fetched instruction; 0 = bubble.
- FetchCount  output  32  number of instructions accepted into IF/ID since reset.
- MisalignedFetch  output  1  sticky misaligned-redirect flag (see Optional Feature).

Behaviour:
- All state updates on posedge clk only. reset is sampled synchronously; reset=0 dominates every other input.
- Reset values:
  - PC=RESET_PC.
  - IFID_Instruction=NOP_WORD.
  - IFID_PCPlus4=0.
  - IFID_Valid=0.
  - FetchCount=0.
  - MisalignedFetch=0.
- PCAddress = PC register, combinational, no extra latency. Instruction is valid in the same cycle; the memory drops Address[1:0] internally.
- PCPlus4 = PC + 4, modulo 2^DATA_WIDTH. 32'hFFFF_FFFC wraps to 32'h0000_0000 with no flag.
- Next-state priority, highest first:
  1. Reset: the reset values above.
  2. Redirect=1:
     - PC <= {RedirectTarget[DATA_WIDTH-1:2],2'b00}.
     - IF/ID flushed: IFID_Instruction<=NOP_WORD, IFID_Valid<=0, IFID_PCPlus4<=0.
     - FetchCount unchanged.
     - Redirect overrides a simultaneous Stall.
  3. Stall=1:
     - PC, IF/ID and FetchCount all hold.
     - Stall may be asserted for any number of consecutive cycles.
  4. Otherwise:
     - PC <= PCPlus4.
     - IFID_Instruction<=Instruction, IFID_PCPlus4<=PCPlus4, IFID_Valid<=1.
     - FetchCount <= FetchCount+1; wraps at 2^32.
- Fetch-to-decode latency: 1 cycle. An instruction at PC in cycle n appears in IF/ID in cycle n+1.
- Redirect penalty: exactly 1 bubble. The target instruction reaches IF/ID one cycle after the flush cycle.
- Reset asserted mid-stall or mid-redirect: the reset values win in that cycle. Fetch restarts at RESET_PC on the first cycle after reset returns high.
- No combinational path from Stall/Redirect to any output; all outputs except PCAddress are register outputs.

Optional Feature:
- Macro: FETCH_MISALIGN_TRAP_EN.
- Defined:
  - A redirect with RedirectTarget[1:0]!=2'b00 sets MisalignedFetch<=1.
  - The flag is sticky until reset.
  - The PC still loads the aligned target.
  - The flag updates only when Redirect wins priority, i.e. not while reset=0.
- Undefined: MisalignedFetch is tied to 0 and the detection logic is absent. Target low bits are silently discarded in both builds.

Test Plan:
- Reset then 4 free-running cycles, memory words 0x20080005, 0x20090003, 0x01095020, 0x00000000 at 0x0,0x4,0x8,0xC:
  - PCAddress goes 0x0,0x4,0x8,0xC,0x10.
  - IF/ID shows each word one cycle later with PCPlus4 0x4..0x10, IFID_Valid=1.
  - FetchCount=4.
- Stall held 3 cycles while PC=0x8:
  - PCAddress stays 0x8.
  - IF/ID stays at the 0x4 word with PCPlus4=0x8.
  - FetchCount frozen.
  - Fetch resumes at 0x8 after release.
- Redirect=1, RedirectTarget=0x40 while PC=0x10:
  - Next cycle PCAddress=0x40 and IFID_Valid=0 holding NOP_WORD.
  - The following cycle IF/ID holds the word at 0x40 with PCPlus4=0x44.
- Redirect and Stall both 1, target 0x20: redirect wins, PC=0x20 and IF/ID flushed.
- Redirect target 0x22:
  - PC=0x20.
  - With FETCH_MISALIGN_TRAP_EN, MisalignedFetch=1 and stays 1 through 10 more cycles until reset=0; without the macro it stays 0.
- PC preset to 0xFFFFFFFC via redirect, one free cycle: PCAddress=0x00000000 and IFID_PCPlus4=0x00000000. Then reset=0 during a stall: all outputs return to reset values next edge.
